// File: rtl/logic_result_stage_if.sv
// Handshake and data bundle between the logic unit, the result stage and its consumer.
// The slave modport is the result stage; the master modport is the surrounding logic.
interface logic_result_stage_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] or_;
  logic [WIDTH-1:0] and_;
  logic [WIDTH-1:0] xor_;
  logic [WIDTH-1:0] not_;
  logic [1:0]       switch;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             neg;
  logic [1:0]       op_out;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  or_, and_, xor_, not_, switch, in_valid, out_ready,
    output in_ready, out, zero, neg, op_out, out_valid
  );

  modport master (
    output or_, and_, xor_, not_, switch, in_valid, out_ready,
    input  in_ready, out, zero, neg, op_out, out_valid
  );
endinterface

// File: rtl/logic_result_stage.sv
// Result select plus 2-entry output FIFO for the logic unit, with zero/neg flags
// and a wrapping count of results handed to the consumer.
module logic_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_result_stage_if.slave bus,
  output logic [CNT_W-1:0]    done_cnt
);

  logic [WIDTH-1:0] res_q  [2];
  logic             zero_q [2];
  logic             neg_q  [2];
  logic [1:0]       op_q   [2];

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] sel_res;
  logic             sel_zero;
  logic             sel_neg;
  logic             in_ready_w;
  logic             out_valid_w;
  logic             push;
  logic             pop;

  always_comb begin
    sel_res = '0;
    case (bus.switch)
      2'b00:   sel_res = bus.or_;
      2'b01:   sel_res = bus.and_;
      2'b10:   sel_res = bus.xor_;
      default: sel_res = bus.not_;
    endcase
    sel_zero = (sel_res == '0);
    sel_neg  = sel_res[WIDTH-1];
  end

  // in_ready comes only from registered occupancy, never from out_ready
  assign in_ready_w  = (occ_q < 2'd2);
  assign out_valid_w = (occ_q != 2'd0);
  assign push        = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        zero_q[i] <= 1'b0;
        neg_q[i]  <= 1'b0;
        op_q[i]   <= 2'b00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      if (push) begin
        res_q[wr_ptr_q]  <= sel_res;
        zero_q[wr_ptr_q] <= sel_zero;
        neg_q[wr_ptr_q]  <= sel_neg;
        op_q[wr_ptr_q]   <= bus.switch;
      end
    end
  end

  // Head fields are forced to zero whenever nothing is buffered
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out       = out_valid_w ? res_q[rd_ptr_q]  : '0;
  assign bus.zero      = out_valid_w ? zero_q[rd_ptr_q] : 1'b0;
  assign bus.neg       = out_valid_w ? neg_q[rd_ptr_q]  : 1'b0;
  assign bus.op_out    = out_valid_w ? op_q[rd_ptr_q]   : 2'b00;
  assign done_cnt      = cnt_q;

endmodule
